// File: rtl/game_if.sv
// Handshake bundle between the 1P game control unit and its environment
// (number generator, player input, display).
interface game_if;
    logic       START;
    logic       OK;
    logic [3:0] NUM;
    logic       ANS_VALID;
    logic [3:0] ANS;
    logic       READY_1P;
    logic [3:0] STATE;
    logic [3:0] Q;
    logic [3:0] SCORE;
    logic [1:0] LIFE;

    modport master (
        output START, OK, NUM, ANS_VALID, ANS,
        input  READY_1P, STATE, Q, SCORE, LIFE
    );

    modport slave (
        input  START, OK, NUM, ANS_VALID, ANS,
        output READY_1P, STATE, Q, SCORE, LIFE
    );
endinterface

// File: rtl/game_ctrl.sv
// Control FSM for the 1P factorization game: requests a number, poses it,
// judges the player's factor answer and keeps score and lives.
module game_ctrl #(
    parameter int LAT         = 3,
    parameter int CNT_W       = 29,
    parameter int ANS_TIMEOUT = 500_000_000,
    parameter int HOLD        = 100_000_000,
    parameter int WIN_SCORE   = 5,
    parameter int LIVES       = 3
) (
    input  logic  CLK,
    input  logic  RST,
    game_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE     = 4'b0000,
        REQ      = 4'b0001,
        WAIT_NUM = 4'b0010,
        ASK      = 4'b0011,
        JUDGE    = 4'b0100,
        DRAW     = 4'b0110,
        GOOD     = 4'b1000,
        OUCH     = 4'b1001,
        WIN      = 4'b1010,
        LOSE     = 4'b1011
    } state_t;

    localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ANS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       LIFE_INIT = 2'(LIVES);
    localparam logic [3:0]       WIN_THR   = 4'(WIN_SCORE);

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [1:0] sat_dec2(input logic [1:0] v);
        return (v == 2'd0) ? v : v - 2'd1;
    endfunction

    function automatic logic is_prime(input logic [3:0] v);
        case (v)
            4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    // Primes expect the "no factor" answer 0; composites need a proper divisor.
    function automatic logic answer_ok(input logic [3:0] q, input logic [3:0] a);
        if (is_prime(q))
            return (a == 4'd0);
        if (a > 4'd1 && a < q)
            return ((q % a) == 4'd0);
        return 1'b0;
    endfunction

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic [3:0]       q_q, q_d;
    logic [3:0]       ans_q, ans_d;
    logic [3:0]       score_q, score_d;
    logic [1:0]       life_q, life_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        ans_d   = ans_q;
        score_d = score_q;
        life_d  = life_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = CNT_ZERO;
                if (bus.START) begin
                    score_d = 4'd0;
                    life_d  = LIFE_INIT;
                    state_d = REQ;
                end
            end

            REQ: begin
                cnt_d   = CNT_ZERO;
                state_d = WAIT_NUM;
            end

            // Counter parks at LAT-1 until the generator reports OK.
            WAIT_NUM: begin
                if (cnt_q == LAT_LAST) begin
                    if (bus.OK) begin
                        q_d     = bus.NUM;
                        cnt_d   = CNT_ZERO;
                        state_d = ASK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ASK: begin
                if (q_q < 4'd2) begin
                    cnt_d   = CNT_ZERO;
                    state_d = DRAW;
                end else if (bus.ANS_VALID) begin
                    ans_d   = bus.ANS;
                    cnt_d   = CNT_ZERO;
                    state_d = JUDGE;
                end else if (cnt_q == TO_LAST) begin
                    life_d  = sat_dec2(life_q);
                    cnt_d   = CNT_ZERO;
                    state_d = OUCH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            JUDGE: begin
                cnt_d = CNT_ZERO;
                if (answer_ok(q_q, ans_q)) begin
                    score_d = sat_inc4(score_q);
                    state_d = GOOD;
                end else begin
                    life_d  = sat_dec2(life_q);
                    state_d = OUCH;
                end
            end

            // Running out of lives takes priority over reaching the win score.
            DRAW, GOOD, OUCH: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (life_q == 2'd0)
                        state_d = LOSE;
                    else if (score_q >= WIN_THR)
                        state_d = WIN;
                    else
                        state_d = REQ;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            WIN, LOSE: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == REQ);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            q_q     <= 4'd0;
            ans_q   <= 4'd0;
            score_q <= 4'd0;
            life_q  <= LIFE_INIT;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            q_q     <= q_d;
            ans_q   <= ans_d;
            score_q <= score_d;
            life_q  <= life_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.READY_1P = ready_q;
    assign bus.STATE    = state_q;
    assign bus.Q        = q_q;
    assign bus.SCORE    = score_q;
    assign bus.LIFE     = life_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: plays rounds against a rule-level model of the game
// with a generator model that answers READY_1P after LAT cycles.
module tb_game_ctrl;

    localparam int LAT   = 3;
    localparam int HOLD  = 4;
    localparam int TMO   = 20;
    localparam int WINS  = 5;
    localparam int LIVES = 3;

    localparam logic [3:0] S_IDLE  = 4'b0000;
    localparam logic [3:0] S_REQ   = 4'b0001;
    localparam logic [3:0] S_WAIT  = 4'b0010;
    localparam logic [3:0] S_ASK   = 4'b0011;
    localparam logic [3:0] S_JUDGE = 4'b0100;
    localparam logic [3:0] S_DRAW  = 4'b0110;
    localparam logic [3:0] S_GOOD  = 4'b1000;
    localparam logic [3:0] S_OUCH  = 4'b1001;
    localparam logic [3:0] S_WIN   = 4'b1010;
    localparam logic [3:0] S_LOSE  = 4'b1011;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    game_if bus ();

    game_ctrl #(
        .LAT(LAT), .CNT_W(29), .ANS_TIMEOUT(TMO), .HOLD(HOLD),
        .WIN_SCORE(WINS), .LIVES(LIVES)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_score;
    logic [1:0] exp_life;
    bit         game_over;

    task automatic step();
        @(negedge CLK);
    endtask

    function automatic bit ref_prime(int q);
        int n = 0;
        for (int d = 2; d < q; d++)
            if (q % d == 0) n++;
        return (q >= 2) && (n == 0);
    endfunction

    function automatic bit ref_correct(int q, int a);
        if (q < 2) return 1'b0;
        if (ref_prime(q)) return (a == 0);
        return (a > 1) && (a < q) && (q % a == 0);
    endfunction

    function automatic int pick_correct(int q);
        int f[$];
        if (q < 2 || ref_prime(q)) return 0;
        for (int d = 2; d < q; d++)
            if (q % d == 0) f.push_back(d);
        return f[$urandom_range(0, f.size() - 1)];
    endfunction

    task automatic start_game();
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        exp_score = 4'd0;
        exp_life  = 2'(LIVES);
        game_over = 1'b0;
    endtask

    // delay < 0: player never answers. Starts anywhere before REQ, ends on the
    // cycle after the result hold (REQ, or IDLE after WIN/LOSE).
    task automatic play_round(input int num, input int delay, input int ans,
                              input int ok_extra, input string tag);
        int         w = 0;
        bit         held = 1'b1;
        logic [3:0] res;
        logic [3:0] nxt;
        logic [3:0] n4;
        logic [3:0] a4;
        n4 = num[3:0];
        a4 = ans[3:0];
        while (bus.STATE !== S_REQ && w < 200) begin
            step();
            w++;
        end
        checks++;
        if (bus.STATE !== S_REQ) begin
            errors++;
            $display("FAIL %s req_wait: STATE=%b required %b", tag, bus.STATE, S_REQ);
            return;
        end
        checks++;
        if (bus.READY_1P !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_high: READY_1P=%b required 1", tag, bus.READY_1P);
        end
        bus.OK  = 1'b0;
        bus.NUM = 4'($urandom_range(0, 15));
        step();
        checks++;
        if (bus.READY_1P !== 1'b0 || bus.STATE !== S_WAIT) begin
            errors++;
            $display("FAIL %s ready_pulse: READY_1P=%b STATE=%b required 0/%b",
                     tag, bus.READY_1P, bus.STATE, S_WAIT);
        end
        for (int i = 1; i < LAT + ok_extra; i++) step();
        checks++;
        if (bus.STATE !== S_WAIT) begin
            errors++;
            $display("FAIL %s wait_hold: STATE=%b required %b", tag, bus.STATE, S_WAIT);
        end
        bus.OK  = 1'b1;
        bus.NUM = n4;
        step();
        bus.OK = 1'b0;
        checks++;
        if (bus.STATE !== S_ASK || bus.Q !== n4) begin
            errors++;
            $display("FAIL %s capture: STATE=%b Q=%0d required %b/%0d",
                     tag, bus.STATE, bus.Q, S_ASK, n4);
        end

        if (num < 2) begin
            bus.ANS_VALID = 1'b1;
            bus.ANS       = a4;
            step();
            bus.ANS_VALID = 1'b0;
            res = S_DRAW;
        end else if (delay >= 0) begin
            for (int i = 0; i < delay; i++) begin
                bus.START = (i == 0);
                step();
                bus.START = 1'b0;
            end
            bus.ANS_VALID = 1'b1;
            bus.ANS       = a4;
            step();
            bus.ANS_VALID = 1'b0;
            checks++;
            if (bus.STATE !== S_JUDGE) begin
                errors++;
                $display("FAIL %s judge: STATE=%b required %b", tag, bus.STATE, S_JUDGE);
            end
            step();
            res = ref_correct(num, ans) ? S_GOOD : S_OUCH;
        end else begin
            for (int i = 0; i < TMO - 1; i++) begin
                bus.START = (i == 0);
                step();
                bus.START = 1'b0;
            end
            checks++;
            if (bus.STATE !== S_ASK) begin
                errors++;
                $display("FAIL %s pre_timeout: STATE=%b required %b", tag, bus.STATE, S_ASK);
            end
            step();
            res = S_OUCH;
        end

        if (res == S_GOOD && exp_score != 4'hF) exp_score = exp_score + 4'd1;
        if (res == S_OUCH && exp_life != 2'd0)  exp_life  = exp_life - 2'd1;
        checks++;
        if (bus.STATE !== res || bus.SCORE !== exp_score || bus.LIFE !== exp_life) begin
            errors++;
            $display("FAIL %s result: STATE=%b SCORE=%0d LIFE=%0d required %b/%0d/%0d (q=%0d a=%0d)",
                     tag, bus.STATE, bus.SCORE, bus.LIFE, res, exp_score, exp_life, num, ans);
        end
        for (int i = 0; i < HOLD - 1; i++) begin
            step();
            if (bus.STATE !== res) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL %s hold: result %b not held %0d cycles", tag, res, HOLD);
        end
        step();
        if (exp_life == 2'd0)             nxt = S_LOSE;
        else if (exp_score >= 4'(WINS))   nxt = S_WIN;
        else                              nxt = S_REQ;
        checks++;
        if (bus.STATE !== nxt) begin
            errors++;
            $display("FAIL %s after_hold: STATE=%b required %b", tag, bus.STATE, nxt);
        end
        if (nxt != S_REQ) begin
            held = 1'b1;
            for (int i = 0; i < HOLD - 1; i++) begin
                step();
                if (bus.STATE !== nxt) held = 1'b0;
            end
            step();
            checks++;
            if (!held || bus.STATE !== S_IDLE || bus.SCORE !== exp_score || bus.LIFE !== exp_life) begin
                errors++;
                $display("FAIL %s end_game: held=%0d STATE=%b SCORE=%0d LIFE=%0d required 1/%b/%0d/%0d",
                         tag, held, bus.STATE, bus.SCORE, bus.LIFE, S_IDLE, exp_score, exp_life);
            end
            game_over = 1'b1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        checks++;
        if (bus.STATE !== S_IDLE || bus.READY_1P !== 1'b0 || bus.Q !== 4'd0 ||
            bus.SCORE !== 4'd0 || bus.LIFE !== 2'(LIVES)) begin
            errors++;
            $display("FAIL reset: STATE=%b RDY=%b Q=%0d SCORE=%0d LIFE=%0d required 0000/0/0/0/%0d",
                     bus.STATE, bus.READY_1P, bus.Q, bus.SCORE, bus.LIFE, LIVES);
        end
        RST = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (bus.STATE !== S_IDLE || bus.READY_1P !== 1'b0) begin
            errors++;
            $display("FAIL idle_stays: STATE=%b RDY=%b required 0000/0", bus.STATE, bus.READY_1P);
        end
    endtask

    task automatic test_directed_lose();
        start_game();
        play_round(6, 2, 3, 0, "q6_a3");
        play_round(7, 1, 0, 0, "q7_a0");
        play_round(7, 0, 7, 1, "q7_a7");
        play_round(9, -1, 0, 2, "q9_timeout");
        play_round(4, 3, 3, 0, "q4_a3_lose");
        checks++;
        if (!game_over) begin
            errors++;
            $display("FAIL lose_reached: game_over=0 required 1");
        end
    endtask

    task automatic test_draw_win();
        int q;
        start_game();
        play_round(1, 0, 5, 0, "draw_q1");
        play_round(0, 0, 0, 1, "draw_q0");
        for (int r = 0; r < WINS; r++) begin
            q = $urandom_range(2, 15);
            play_round(q, $urandom_range(0, TMO - 1), pick_correct(q),
                       $urandom_range(0, 3), "win_run");
        end
        checks++;
        if (!game_over || bus.SCORE !== 4'(WINS)) begin
            errors++;
            $display("FAIL win_reached: over=%0d SCORE=%0d required 1/%0d",
                     game_over, bus.SCORE, WINS);
        end
    endtask

    task automatic test_timeout_race();
        start_game();
        play_round(6, TMO - 1, 2, 0, "race_good");
        play_round(8, TMO - 1, 3, 0, "race_ouch");
    endtask

    task automatic test_reset_mid();
        // Game left mid-round at REQ: reset must cut the READY_1P pulse.
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (bus.STATE !== S_IDLE || bus.READY_1P !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_req: STATE=%b RDY=%b required 0000/0", bus.STATE, bus.READY_1P);
        end
        step();
        RST = 1'b0;
        bus.OK  = 1'b1;
        bus.NUM = 4'd5;
        start_game();
        for (int i = 0; i < LAT + 1; i++) step();
        bus.OK = 1'b0;
        checks++;
        if (bus.STATE !== S_ASK || bus.Q !== 4'd5) begin
            errors++;
            $display("FAIL reach_ask: STATE=%b Q=%0d required %b/5", bus.STATE, bus.Q, S_ASK);
        end
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (bus.STATE !== S_IDLE || bus.Q !== 4'd0 || bus.SCORE !== 4'd0 ||
            bus.LIFE !== 2'(LIVES) || bus.READY_1P !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ask: STATE=%b Q=%0d SCORE=%0d LIFE=%0d RDY=%b required 0000/0/0/%0d/0",
                     bus.STATE, bus.Q, bus.SCORE, bus.LIFE, bus.READY_1P, LIVES);
        end
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic test_random_games();
        int q, d, a;
        for (int g = 0; g < 3; g++) begin
            start_game();
            for (int r = 0; r < 40 && !game_over; r++) begin
                q = $urandom_range(0, 15);
                d = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TMO - 1);
                a = $urandom_range(0, 1) ? pick_correct(q) : $urandom_range(0, 15);
                play_round(q, d, a, $urandom_range(0, 3), "random");
            end
            if (!game_over) begin
                RST = 1'b1;
                step();
                RST = 1'b0;
                step();
            end
        end
    endtask

    initial begin
        RST           = 1'b1;
        bus.START     = 1'b0;
        bus.OK        = 1'b0;
        bus.NUM       = 4'd0;
        bus.ANS_VALID = 1'b0;
        bus.ANS       = 4'd0;
        test_reset();
        test_directed_lose();
        test_draw_win();
        test_timeout_race();
        test_reset_mid();
        test_random_games();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
